// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC decode stage: opcode encodings,
// the ID/EX control bundle and the halt-drain FSM states.
package wisc_pkg;

    localparam int CNT_W = 4;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    typedef struct packed {
        logic reg_wren;
        logic mem_to_reg;
        logic mem_wr;
        logic alu_src;
        logic dst_reg_sel;
        logic branch;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure opcode decoder: produces the six-bit control bundle and a flag
// telling the hazard unit whether the instruction really reads rt.
module ctrl_decode
    import wisc_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl,
    output logic       rt_read
);

    // Opcode to control bundle; anything that does not write via rt selects rd.
    always_comb begin
        ctrl             = '0;
        ctrl.dst_reg_sel = 1'b1;
        rt_read          = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_XOR, OP_PADDSB, OP_RED: begin
                ctrl.reg_wren = 1'b1;
                rt_read       = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                ctrl.reg_wren = 1'b1;
                ctrl.alu_src  = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_wren    = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.dst_reg_sel = 1'b0;
            end
            OP_SW: begin
                ctrl.mem_wr  = 1'b1;
                ctrl.alu_src = 1'b1;
                rt_read      = 1'b1;
            end
            OP_LLB, OP_LHB, OP_PCS: begin
                ctrl.reg_wren = 1'b1;
            end
            OP_B, OP_BR: begin
                ctrl.branch = 1'b1;
            end
            OP_HLT: begin
                ctrl.branch = 1'b0;
            end
            default: begin
                ctrl             = '0;
                ctrl.dst_reg_sel = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Decode-stage controller: owns the control half of ID/EX, detects
// load-use hazards, flushes on taken branches, freezes on mem_busy and
// drains the pipeline after HLT. DRAIN must lie in 1..15.
module decode_ctrl_stage
    import wisc_pkg::*;
#(
    parameter int RA_W  = 4,
    parameter int DRAIN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [3:0]      opcode,
    input  logic [RA_W-1:0] rs,
    input  logic [RA_W-1:0] rt,
    input  logic [RA_W-1:0] rd,
    input  logic            branch_taken,
    input  logic            mem_busy,
    output logic            ex_valid,
    output logic            ex_reg_wren,
    output logic            ex_mem_to_reg,
    output logic            ex_mem_wr,
    output logic            ex_alu_src,
    output logic            ex_dst_reg_sel,
    output logic            ex_branch,
    output logic [RA_W-1:0] ex_dst,
    output logic            pc_stall,
    output logic            if_id_stall,
    output logic            if_id_flush,
    output logic            halted
);

    ctrl_t              dec_ctrl_s;
    logic               rt_read_s;
    logic               load_use_s;
    logic               is_hlt_s;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               halted_r;

    logic               ex_valid_r;
    ctrl_t              ex_ctrl_r;
    logic [RA_W-1:0]    ex_dst_r;

    logic               nxt_valid_s;
    ctrl_t              nxt_ctrl_s;
    logic [RA_W-1:0]    nxt_dst_s;
    logic               hold_s;
    logic               pc_stall_s;
    logic               if_id_stall_s;
    logic               if_id_flush_s;

    ctrl_decode u_ctrl_decode (
        .opcode  (opcode),
        .ctrl    (dec_ctrl_s),
        .rt_read (rt_read_s)
    );

    // A load in EX whose destination feeds the instruction in ID; r0 never hazards.
    always_comb begin
        load_use_s = ex_valid_r && ex_ctrl_r.mem_to_reg &&
                     (ex_dst_r != {RA_W{1'b0}}) && id_valid &&
                     ((ex_dst_r == rs) || ((ex_dst_r == rt) && rt_read_s));
        is_hlt_s   = id_valid && (opcode == OP_HLT);
    end

    // Next-state, stall/flush lines and next ID/EX contents, in priority order.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        hold_s        = 1'b0;
        pc_stall_s    = 1'b0;
        if_id_stall_s = 1'b0;
        if_id_flush_s = 1'b0;
        nxt_valid_s   = 1'b0;
        nxt_ctrl_s    = '0;
        nxt_dst_s     = {RA_W{1'b0}};
        if (rst) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (mem_busy) begin
            hold_s        = 1'b1;
            pc_stall_s    = 1'b1;
            if_id_stall_s = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (is_hlt_s && !branch_taken && !load_use_s) begin
                        state_nxt_s = ST_DRAIN;
                        cnt_nxt_s   = CNT_W'(DRAIN - 1);
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_nxt_s = ST_HALT;
                    end else begin
                        cnt_nxt_s = cnt_r - 4'd1;
                    end
                end
                ST_HALT: begin
                    state_nxt_s = ST_HALT;
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase

            if (branch_taken) begin
                if_id_flush_s = 1'b1;
            end else if (state_r != ST_RUN) begin
                pc_stall_s    = 1'b1;
                if_id_stall_s = 1'b1;
            end else if (load_use_s) begin
                pc_stall_s    = 1'b1;
                if_id_stall_s = 1'b1;
            end else if (is_hlt_s) begin
                nxt_valid_s = 1'b0;
            end else if (id_valid) begin
                nxt_valid_s = 1'b1;
                nxt_ctrl_s  = dec_ctrl_s;
                nxt_dst_s   = dec_ctrl_s.dst_reg_sel ? rd : rt;
            end else begin
                nxt_valid_s = 1'b0;
            end
        end
    end

    // ID/EX control register, FSM state, drain counter and halted flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            cnt_r      <= {CNT_W{1'b0}};
            halted_r   <= 1'b0;
            ex_valid_r <= 1'b0;
            ex_ctrl_r  <= '0;
            ex_dst_r   <= {RA_W{1'b0}};
        end else if (!hold_s) begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            halted_r   <= (state_nxt_s == ST_HALT);
            ex_valid_r <= nxt_valid_s;
            ex_ctrl_r  <= nxt_ctrl_s;
            ex_dst_r   <= nxt_dst_s;
        end
    end

    assign ex_valid       = ex_valid_r;
    assign ex_reg_wren    = ex_ctrl_r.reg_wren;
    assign ex_mem_to_reg  = ex_ctrl_r.mem_to_reg;
    assign ex_mem_wr      = ex_ctrl_r.mem_wr;
    assign ex_alu_src     = ex_ctrl_r.alu_src;
    assign ex_dst_reg_sel = ex_ctrl_r.dst_reg_sel;
    assign ex_branch      = ex_ctrl_r.branch;
    assign ex_dst         = ex_dst_r;
    assign halted         = halted_r;
    assign pc_stall       = pc_stall_s;
    assign if_id_stall    = if_id_stall_s;
    assign if_id_flush    = if_id_flush_s;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: each step drives one cycle of
// IF/ID inputs, checks the combinational stall/flush lines, pushes the
// expected ID/EX contents and compares them after the clock edge.
module tb_decode_ctrl_stage;
    import wisc_pkg::*;

    logic       clk = 1'b0;
    logic       rst, id_valid, branch_taken, mem_busy;
    logic [3:0] opcode, rs, rt, rd;
    logic       ex_valid, ex_reg_wren, ex_mem_to_reg, ex_mem_wr;
    logic       ex_alu_src, ex_dst_reg_sel, ex_branch;
    logic [3:0] ex_dst;
    logic       pc_stall, if_id_stall, if_id_flush, halted;

    int checks   = 0;
    int failures = 0;
    logic [11:0] sb[$];
    logic [11:0] obs_s;

    // Control bundles {reg_wren, mem_to_reg, mem_wr, alu_src, dst_reg_sel, branch}
    localparam logic [5:0] C_ALU = 6'b100010;
    localparam logic [5:0] C_SW  = 6'b001110;
    localparam logic [5:0] C_LW  = 6'b110100;
    localparam logic [5:0] C_SHF = 6'b100110;
    localparam logic [5:0] C_BR  = 6'b000011;
    localparam logic [2:0] NONE  = 3'b000;
    localparam logic [2:0] STL   = 3'b110;
    localparam logic [2:0] FLS   = 3'b001;
    localparam logic [11:0] BUB0 = 12'h000;
    localparam logic [11:0] BUB1 = 12'h001;

    decode_ctrl_stage #(.RA_W(4), .DRAIN(3)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .ex_valid(ex_valid), .ex_reg_wren(ex_reg_wren),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_wr(ex_mem_wr),
        .ex_alu_src(ex_alu_src), .ex_dst_reg_sel(ex_dst_reg_sel),
        .ex_branch(ex_branch), .ex_dst(ex_dst), .pc_stall(pc_stall),
        .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .halted(halted)
    );

    always #5 clk = ~clk;

    assign obs_s = {ex_valid, ex_reg_wren, ex_mem_to_reg, ex_mem_wr, ex_alu_src,
                    ex_dst_reg_sel, ex_branch, ex_dst, halted};

    function automatic logic [11:0] mk(input logic [5:0] c, input logic [3:0] d);
        return {1'b1, c, d, 1'b0};
    endfunction

    task automatic step(input string tag, input logic r, input logic iv,
                        input logic [3:0] op, input logic [3:0] rs_v,
                        input logic [3:0] rt_v, input logic [3:0] rd_v,
                        input logic bt, input logic mb,
                        input logic [2:0] ec, input logic [11:0] er);
        logic [11:0] exp_v;
        @(negedge clk);
        rst = r; id_valid = iv; opcode = op; rs = rs_v; rt = rt_v; rd = rd_v;
        branch_taken = bt; mem_busy = mb;
        #1;
        checks++;
        assert ({pc_stall, if_id_stall, if_id_flush} === ec) else begin
            failures++;
            $error("FAIL %s comb stall/stall/flush obs=%b exp=%b", tag,
                   {pc_stall, if_id_stall, if_id_flush}, ec);
        end
        sb.push_back(er);
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        checks++;
        assert (obs_s === exp_v) else begin
            failures++;
            $error("FAIL %s idex {v,ctrl6,dst4,halted} obs=%b exp=%b", tag, obs_s, exp_v);
        end
    endtask

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; opcode = 4'h0; rs = 4'h0; rt = 4'h0; rd = 4'h0;
        branch_taken = 1'b0; mem_busy = 1'b0;

        // reset and basic decode
        step("rst0",     1'b1, 1'b1, OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, NONE, BUB0);
        step("rst1",     1'b1, 1'b1, OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, NONE, BUB0);
        step("add",      1'b0, 1'b1, OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, NONE, mk(C_ALU, 4'd3));
        step("sw",       1'b0, 1'b1, OP_SW,  4'd1, 4'd5, 4'd6, 1'b0, 1'b0, NONE, mk(C_SW, 4'd6));

        // load-use on rs
        step("lw_r4",    1'b0, 1'b1, OP_LW,  4'd1, 4'd4, 4'd7, 1'b0, 1'b0, NONE, mk(C_LW, 4'd4));
        step("lu_rs",    1'b0, 1'b1, OP_ADD, 4'd4, 4'd2, 4'd8, 1'b0, 1'b0, STL,  BUB0);
        step("lu_issue", 1'b0, 1'b1, OP_ADD, 4'd4, 4'd2, 4'd8, 1'b0, 1'b0, NONE, mk(C_ALU, 4'd8));
        // load-use on rt for an rt reader
        step("lw_r9",    1'b0, 1'b1, OP_LW,  4'd1, 4'd9, 4'd7, 1'b0, 1'b0, NONE, mk(C_LW, 4'd9));
        step("lu_rt",    1'b0, 1'b1, OP_SW,  4'd1, 4'd9, 4'd2, 1'b0, 1'b0, STL,  BUB0);
        step("lu_rt_is", 1'b0, 1'b1, OP_SW,  4'd1, 4'd9, 4'd2, 1'b0, 1'b0, NONE, mk(C_SW, 4'd2));
        // rt match on a non-reader: no hazard
        step("lw_r3",    1'b0, 1'b1, OP_LW,  4'd1, 4'd3, 4'd7, 1'b0, 1'b0, NONE, mk(C_LW, 4'd3));
        step("sll_nohz", 1'b0, 1'b1, OP_SLL, 4'd1, 4'd3, 4'd5, 1'b0, 1'b0, NONE, mk(C_SHF, 4'd5));
        // load to r0 never hazards
        step("lw_r0",    1'b0, 1'b1, OP_LW,  4'd1, 4'd0, 4'd7, 1'b0, 1'b0, NONE, mk(C_LW, 4'd0));
        step("r0_nohz",  1'b0, 1'b1, OP_ADD, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0, NONE, mk(C_ALU, 4'd6));

        // branch flush beats load-use; flushed HLT is not captured
        step("lw_r4b",   1'b0, 1'b1, OP_LW,  4'd1, 4'd4, 4'd7, 1'b0, 1'b0, NONE, mk(C_LW, 4'd4));
        step("bt_vs_lu", 1'b0, 1'b1, OP_ADD, 4'd4, 4'd2, 4'd8, 1'b1, 1'b0, FLS,  BUB0);
        step("bt_hlt",   1'b0, 1'b1, OP_HLT, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, FLS,  BUB0);
        step("after_bt", 1'b0, 1'b1, OP_ADD, 4'd1, 4'd2, 4'd9, 1'b0, 1'b0, NONE, mk(C_ALU, 4'd9));
        // id_valid=0 cannot hazard
        step("lw_r4c",   1'b0, 1'b1, OP_LW,  4'd1, 4'd4, 4'd7, 1'b0, 1'b0, NONE, mk(C_LW, 4'd4));
        step("iv0",      1'b0, 1'b0, OP_ADD, 4'd4, 4'd4, 4'd8, 1'b0, 1'b0, NONE, BUB0);

        // HLT drain with a 4-cycle freeze: halted delayed by 4
        step("hlt",      1'b0, 1'b1, OP_HLT, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, NONE, BUB0);
        step("drain_a",  1'b0, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, STL,  BUB0);
        for (int i = 0; i < 4; i++)
            step("drain_mb", 1'b0, 1'b1, OP_ADD, 4'd1, 4'd1, 4'd1, 1'b0, 1'b1, STL, BUB0);
        step("drain_b",  1'b0, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, STL,  BUB0);
        step("drain_c",  1'b0, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, STL,  BUB1);
        step("halt_a",   1'b0, 1'b1, OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, STL,  BUB1);
        step("halt_b",   1'b0, 1'b1, OP_HLT, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, STL,  BUB1);

        // rst in HALT, then an unfrozen drain of exactly DRAIN cycles
        step("rst_halt", 1'b1, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, NONE, BUB0);
        step("hlt2",     1'b0, 1'b1, OP_HLT, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, NONE, BUB0);
        step("dr2_a",    1'b0, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, STL,  BUB0);
        step("dr2_b",    1'b0, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, STL,  BUB0);
        step("dr2_c",    1'b0, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, STL,  BUB1);
        step("halt2",    1'b0, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, STL,  BUB1);

        // rst mid-drain returns to RUN
        step("rst2",     1'b1, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, NONE, BUB0);
        step("hlt3",     1'b0, 1'b1, OP_HLT, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, NONE, BUB0);
        step("dr3_a",    1'b0, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, STL,  BUB0);
        step("rst_mid",  1'b1, 1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, NONE, BUB0);
        step("run_add",  1'b0, 1'b1, OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, NONE, mk(C_ALU, 4'd3));

        // mem_busy freeze during a load-use stall; busy masks a branch too
        step("lw_r4d",   1'b0, 1'b1, OP_LW,  4'd1, 4'd4, 4'd7, 1'b0, 1'b0, NONE, mk(C_LW, 4'd4));
        step("lu_mb0",   1'b0, 1'b1, OP_ADD, 4'd4, 4'd2, 4'd8, 1'b0, 1'b1, STL,  mk(C_LW, 4'd4));
        step("lu_mb1",   1'b0, 1'b1, OP_ADD, 4'd4, 4'd2, 4'd8, 1'b1, 1'b1, STL,  mk(C_LW, 4'd4));
        step("lu_mb2",   1'b0, 1'b1, OP_ADD, 4'd4, 4'd2, 4'd8, 1'b0, 1'b1, STL,  mk(C_LW, 4'd4));
        step("lu_mb3",   1'b0, 1'b1, OP_ADD, 4'd4, 4'd2, 4'd8, 1'b0, 1'b1, STL,  mk(C_LW, 4'd4));
        step("lu_stall", 1'b0, 1'b1, OP_ADD, 4'd4, 4'd2, 4'd8, 1'b0, 1'b0, STL,  BUB0);
        step("lu_go",    1'b0, 1'b1, OP_ADD, 4'd4, 4'd2, 4'd8, 1'b0, 1'b0, NONE, mk(C_ALU, 4'd8));

        // remaining decode classes
        step("branch",   1'b0, 1'b1, OP_B,   4'd1, 4'd2, 4'd5, 1'b0, 1'b0, NONE, mk(C_BR, 4'd5));
        step("llb",      1'b0, 1'b1, OP_LLB, 4'd1, 4'd2, 4'd10, 1'b0, 1'b0, NONE, mk(C_ALU, 4'd10));
        step("ror",      1'b0, 1'b1, OP_ROR, 4'd1, 4'd2, 4'd11, 1'b0, 1'b0, NONE, mk(C_SHF, 4'd11));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
